// File: rtl/cabac_bit_fetcher_if.sv
// Byte-source and decoder-side signal bundle for the CABAC bit fetcher.
// master = source/decoder side, slave = the fetcher itself.
interface cabac_bit_fetcher_if #(
  parameter int BUF_W    = 32,
  parameter int MAX_BITS = 16
);
  localparam int FW = $clog2(BUF_W + 1);

  logic [7:0]          byte_in;
  logic                byte_ready;
  logic                byte_request;
  logic                rd_valid;
  logic [4:0]          rd_num;
  logic                rd_ack;
  logic [MAX_BITS-1:0] rd_data;
  logic                align_req;
  logic [FW-1:0]       fill_level;
  logic [31:0]         bits_consumed;
  logic                err;

  modport master (
    output byte_in, byte_ready,
    output rd_valid, rd_num, align_req,
    input  byte_request, rd_ack, rd_data,
    input  fill_level, bits_consumed, err
  );

  modport slave (
    input  byte_in, byte_ready,
    input  rd_valid, rd_num, align_req,
    output byte_request, rd_ack, rd_data,
    output fill_level, bits_consumed, err
  );
endinterface

// File: rtl/cabac_bit_fetcher.sv
// Byte stream to MSB-first bit reservoir with variable-length reads,
// byte alignment and consumed-bit accounting for the CABAC engine.
module cabac_bit_fetcher #(
  parameter int BUF_W    = 32,
  parameter int MAX_BITS = 16
) (
  input logic                clk,
  input logic                rst,
  cabac_bit_fetcher_if.slave bus
);
  localparam int FW = $clog2(BUF_W + 1);
  localparam logic [FW-1:0] LIM  = FW'(BUF_W - 8);
  localparam logic [FW-1:0] BYTE = FW'(8);
  localparam logic [4:0]    MAXN = 5'(MAX_BITS);

  logic [BUF_W-1:0]    r_res;
  logic [FW-1:0]       r_fill;
  logic                r_ack;
  logic [MAX_BITS-1:0] r_data;
  logic [31:0]         r_cons;
  logic                r_err;

  logic                w_req;
  logic                w_take;
  logic                w_illegal;
  logic                w_try;
  logic                w_rd;
  logic                w_bad;
  logic [FW-1:0]       w_shamt;
  logic [FW-1:0]       w_fill_s;
  logic [FW-1:0]       w_fill_n;
  logic [BUF_W-1:0]    w_res_s;
  logic [BUF_W-1:0]    w_ins;
  logic [BUF_W-1:0]    w_res_n;
  logic [MAX_BITS-1:0] w_top;

  assign w_req  = !rst && (r_fill <= LIM);
  assign w_take = w_req && bus.byte_ready;

  assign w_illegal = (bus.rd_num == 5'd0)
                  || (bus.rd_num > MAXN);
  assign w_try = bus.rd_valid && !r_ack
              && !bus.align_req;
  assign w_rd  = w_try && !w_illegal
              && (32'(r_fill) >= 32'(bus.rd_num));
  assign w_bad = w_try && w_illegal;

  // align and read never both shift: a read is held off by align_req
  always_comb begin
    w_shamt = '0;
    unique case (1'b1)
      bus.align_req: w_shamt = {{(FW-3){1'b0}}, r_fill[2:0]};
      w_rd:          w_shamt = FW'(bus.rd_num);
      default:       ;
    endcase
  end

  assign w_res_s  = r_res << w_shamt;
  assign w_fill_s = r_fill - w_shamt;

  // new byte lands right under the bits still valid after this edge's shift
  assign w_ins    = {bus.byte_in, {(BUF_W-8){1'b0}}} >> w_fill_s;
  assign w_res_n  = w_take ? (w_res_s | w_ins) : w_res_s;
  assign w_fill_n = w_fill_s + (w_take ? BYTE : '0);

  assign w_top = r_res[BUF_W-1 -: MAX_BITS] >> (MAXN - bus.rd_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res  <= '0;
      r_fill <= '0;
      r_ack  <= 1'b0;
      r_data <= '0;
      r_cons <= '0;
      r_err  <= 1'b0;
    end else begin
      r_res  <= w_res_n;
      r_fill <= w_fill_n;
      r_ack  <= w_rd || w_bad;
      if (w_rd)
        r_data <= w_top;
      else if (w_bad)
        r_data <= '0;
      r_cons <= r_cons + 32'(w_shamt);
      if (w_bad)
        r_err <= 1'b1;
    end
  end

  assign bus.byte_request  = w_req;
  assign bus.rd_ack        = r_ack;
  assign bus.rd_data       = r_data;
  assign bus.fill_level    = r_fill;
  assign bus.bits_consumed = r_cons;
  assign bus.err           = r_err;
endmodule

// File: tb/tb_cabac_bit_fetcher.sv
// Directed bench for cabac_bit_fetcher: table of read/align vectors
// plus hand sequences for stall, illegal length, reset and same-edge fill.
module tb_cabac_bit_fetcher;
  localparam int BUF_W    = 32;
  localparam int MAX_BITS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cabac_bit_fetcher_if #(
    .BUF_W(BUF_W), .MAX_BITS(MAX_BITS)
  ) bus ();

  cabac_bit_fetcher #(
    .BUF_W(BUF_W), .MAX_BITS(MAX_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // upstream byte source: advances when a byte is taken
  logic [7:0] src_mem [0:31];
  int src_wr = 0;
  int src_rd = 0;

  assign bus.byte_ready = (src_rd < src_wr);
  assign bus.byte_in    = src_mem[src_rd[4:0]];

  always @(posedge clk)
    if (bus.byte_request && bus.byte_ready)
      src_rd <= src_rd + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    src_mem[src_wr[4:0]] = b;
    src_wr++;
  endtask

  typedef struct {
    bit         is_align;
    bit         push_en;
    logic [7:0] push_b;
    logic [4:0] num;
    bit         ack;
    logic [15:0] data;
    int         fill;
    int         cons;
  } vec_t;

  vec_t tv [7];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit got;

    tv[0] = '{0, 0, 8'h00, 5'd9, 1, 16'h014A, 23, 9};
    tv[1] = '{0, 0, 8'h00, 5'd7, 1, 16'h003C, 16, 16};
    tv[2] = '{1, 0, 8'h00, 5'd0, 0, 16'h003C, 16, 16};
    tv[3] = '{0, 0, 8'h00, 5'd3, 1, 16'h0007, 13, 19};
    tv[4] = '{1, 0, 8'h00, 5'd0, 0, 16'h0007, 8, 24};
    tv[5] = '{0, 0, 8'h00, 5'd8, 1, 16'h000F, 0, 32};
    tv[6] = '{0, 1, 8'h9C, 5'd4, 1, 16'h0009, 4, 36};

    for (int i = 0; i < 32; i++) src_mem[i] = 8'h00;
    bus.rd_valid  = 1'b0;
    bus.rd_num    = 5'd0;
    bus.align_req = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req",  32'(bus.byte_request), 0);
    chk("rst_fill", 32'(bus.fill_level), 0);
    chk("rst_ack",  32'(bus.rd_ack), 0);
    chk("rst_data", 32'(bus.rd_data), 0);
    chk("rst_cons", bus.bits_consumed, 0);
    chk("rst_err",  32'(bus.err), 0);

    rst = 1'b0;
    #1;
    chk("req_empty", 32'(bus.byte_request), 1);

    push(8'hA5); push(8'h3C); push(8'hF0); push(8'h0F);
    for (int k = 0; k < 20 && bus.fill_level != 32; k++)
      @(negedge clk);
    chk("fill_full", 32'(bus.fill_level), 32);
    chk("req_full",  32'(bus.byte_request), 0);

    for (int i = 0; i < 7; i++) begin
      if (tv[i].push_en) begin
        push(tv[i].push_b);
        @(negedge clk);
      end
      if (tv[i].is_align) bus.align_req = 1'b1;
      else begin
        bus.rd_valid = 1'b1;
        bus.rd_num   = tv[i].num;
      end
      @(negedge clk);
      bus.rd_valid  = 1'b0;
      bus.align_req = 1'b0;
      chk($sformatf("v%0d_ack", i),  32'(bus.rd_ack), 32'(tv[i].ack));
      chk($sformatf("v%0d_data", i), 32'(bus.rd_data), 32'(tv[i].data));
      chk($sformatf("v%0d_fill", i), 32'(bus.fill_level), tv[i].fill);
      chk($sformatf("v%0d_cons", i), bus.bits_consumed, tv[i].cons);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(bus.rd_ack), 0);
    end
    chk("err_clean", 32'(bus.err), 0);

    // starved 16-bit read, released by two late bytes
    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd16;
    repeat (4) begin
      @(negedge clk);
      chk("stall_ack", 32'(bus.rd_ack), 0);
    end
    chk("stall_fill", 32'(bus.fill_level), 4);
    push(8'h12); push(8'h34);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.rd_ack) got = 1'b1;
    end
    chk("hold_ack",  32'(got), 1);
    chk("hold_data", 32'(bus.rd_data), 32'h0000C123);
    chk("hold_fill", 32'(bus.fill_level), 4);
    chk("hold_cons", bus.bits_consumed, 52);
    @(negedge clk);
    chk("no_second_ack", 32'(bus.rd_ack), 0);
    bus.rd_valid = 1'b0;
    @(negedge clk);

    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd0;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("ill0_ack",  32'(bus.rd_ack), 1);
    chk("ill0_data", 32'(bus.rd_data), 0);
    chk("ill0_fill", 32'(bus.fill_level), 4);
    chk("ill0_err",  32'(bus.err), 1);
    @(negedge clk);
    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd17;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("ill17_ack",  32'(bus.rd_ack), 1);
    chk("ill17_fill", 32'(bus.fill_level), 4);
    chk("ill17_cons", bus.bits_consumed, 52);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(bus.err), 1);

    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd2;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("r2_data", 32'(bus.rd_data), 1);
    chk("r2_fill", 32'(bus.fill_level), 2);
    chk("r2_cons", bus.bits_consumed, 54);
    @(negedge clk);

    // reset lands on the same edge as a satisfiable read
    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd2;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_req",  32'(bus.byte_request), 0);
    chk("mrst_ack",  32'(bus.rd_ack), 0);
    chk("mrst_data", 32'(bus.rd_data), 0);
    chk("mrst_fill", 32'(bus.fill_level), 0);
    chk("mrst_cons", bus.bits_consumed, 0);
    chk("mrst_err",  32'(bus.err), 0);
    bus.rd_valid = 1'b0;
    rst = 1'b0;

    push(8'h81); push(8'h42); push(8'h77);
    for (int k = 0; k < 20 && bus.fill_level != 24; k++)
      @(negedge clk);
    chk("se_fill24", 32'(bus.fill_level), 24);
    chk("se_req24",  32'(bus.byte_request), 1);

    // byte accept and read on one edge
    push(8'hE6);
    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd4;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("se_data", 32'(bus.rd_data), 32'h8);
    chk("se_fill", 32'(bus.fill_level), 28);
    chk("se_cons", bus.bits_consumed, 4);
    @(negedge clk);
    bus.rd_valid = 1'b1;
    bus.rd_num   = 5'd16;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("se16_data", 32'(bus.rd_data), 32'h1427);
    chk("se16_fill", 32'(bus.fill_level), 12);
    chk("se16_cons", bus.bits_consumed, 20);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
